// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM state encoding,
// the idle byte-select value and the rotating one-hot picker function.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam logic [1:0] DS_NONE = 2'b11;

    // Searches start, start+1, ... modulo 8. Requesters above NUM_CLIENTS are
    // tied to zero, so the wrap behaves like a modulo-NUM_CLIENTS rotation.
    function automatic logic [2:0] onehot_pick(input logic [7:0] req, input logic [2:0] start);
        logic [2:0] result;
        logic [2:0] idx;
        logic       found;
        result = '0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && req[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational picker: returns the first set request at or after 'start',
// wrapping around. With start tied to 0 it is a plain fixed-priority encoder.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IW-1:0]          start,
    output logic                   valid,
    output logic [IW-1:0]          idx
);

    logic [7:0] req_ext;
    logic [2:0] start_ext;
    logic [2:0] pick;

    for (genvar gi = 0; gi < 8; gi++) begin : g_req
        if (gi < NUM_CLIENTS) begin : g_used
            assign req_ext[gi] = req[gi];
        end else begin : g_pad
            assign req_ext[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_start
        if (gi < IW) begin : g_used
            assign start_ext[gi] = start[gi];
        end else begin : g_pad
            assign start_ext[gi] = 1'b0;
        end
    end

    assign pick  = onehot_pick(req_ext, start_ext);
    assign valid = |req;
    assign idx   = IW'(pick);

endmodule

// File: rtl/sdram_port_arb.sv
// Shares one toggle-handshake SDRAM controller port among NUM_CLIENTS level
// requesters. Define SDRAM_ARB_RR_EN for round-robin instead of fixed priority.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int AW          = 23
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    cl_req,
    input  logic [NUM_CLIENTS-1:0]    cl_we,
    input  logic [NUM_CLIENTS*AW-1:0] cl_a,
    input  logic [NUM_CLIENTS*2-1:0]  cl_ds,
    input  logic [NUM_CLIENTS*16-1:0] cl_d,
    output logic [NUM_CLIENTS-1:0]    cl_ack,
    output logic [15:0]               cl_q,
    output logic                      mem_req,
    input  logic                      mem_ack,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_a,
    output logic [1:0]                mem_ds,
    output logic [15:0]               mem_d,
    input  logic [15:0]               mem_q
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    arb_state_t             state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [AW-1:0]          mem_a_q, mem_a_d;
    logic [1:0]             mem_ds_q, mem_ds_d;
    logic [15:0]            mem_d_q, mem_d_d;
    logic [15:0]            rdata_q, rdata_d;
    logic [NUM_CLIENTS-1:0] cl_ack_q, cl_ack_d;
    logic [IW-1:0]          win_q, win_d;

    logic [AW-1:0]          a_arr  [NUM_CLIENTS];
    logic [1:0]             ds_arr [NUM_CLIENTS];
    logic [15:0]            d_arr  [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] win_onehot;

    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic [IW-1:0]          pick_start;
    logic                   ack_match;
    logic                   issue;

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
        assign a_arr[gi]      = cl_a[gi*AW +: AW];
        assign ds_arr[gi]     = cl_ds[gi*2 +: 2];
        assign d_arr[gi]      = cl_d[gi*16 +: 16];
        assign win_onehot[gi] = (win_q == IW'(gi));
    end

    assign ack_match = (mem_ack == mem_req_q);
    assign issue     = (state_q == IDLE) && pick_valid;

    sdram_arb_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IW          (IW)
    ) u_pick (
        .req   (cl_req),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef SDRAM_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Pointer moves past the winner only when a command is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (pick_idx == IW'(NUM_CLIENTS - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_start = ptr_q;
`else
    assign pick_start = '0;
`endif

    // State register (plus all datapath flops)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SYNC;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_ds_q  <= DS_NONE;
            mem_d_q   <= '0;
            rdata_q   <= '0;
            cl_ack_q  <= '0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_ds_q  <= mem_ds_d;
            mem_d_q   <= mem_d_d;
            rdata_q   <= rdata_d;
            cl_ack_q  <= cl_ack_d;
            win_q     <= win_d;
        end
    end

    // Next-state logic. SYNC absorbs a controller whose ack register was not
    // reset, or a reset that interrupted a transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (ack_match)  state_d = IDLE;
            IDLE:    if (pick_valid) state_d = WAIT;
            WAIT:    if (ack_match)  state_d = DONE;
            DONE:                    state_d = IDLE;
            default:                 state_d = SYNC;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_a_d   = mem_a_q;
        mem_ds_d  = mem_ds_q;
        mem_d_d   = mem_d_q;
        rdata_d   = rdata_q;
        win_d     = win_q;
        cl_ack_d  = '0;
        if (issue) begin
            mem_req_d = ~mem_req_q;
            mem_we_d  = cl_we[pick_idx];
            mem_a_d   = a_arr[pick_idx];
            mem_ds_d  = ds_arr[pick_idx];
            mem_d_d   = d_arr[pick_idx];
            win_d     = pick_idx;
        end
        // The ack flop is loaded on the match edge so it is high for the DONE cycle.
        if ((state_q == WAIT) && ack_match) begin
            cl_ack_d = win_onehot;
            if (!mem_we_q) begin
                rdata_d = mem_q;
            end
        end
    end

    assign cl_ack  = cl_ack_q;
    assign cl_q    = rdata_q;
    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_ds  = mem_ds_q;
    assign mem_d   = mem_d_q;

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Shares one toggle-handshake SDRAM controller port among NUM_CLIENTS level-request clients, e.g. CPU, ROM loader and DMA/tape on port1.
- Arbitrates between clients and latches the winner's command.
- Issues the command as a single req toggle, waits for ack to match req, captures read data and returns a one-cycle ack pulse to the winning client.
- Sits between the client logic and the sdram controller in the clk (SDRAM clock) domain.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8).
- AW, 23, word address width (address bits [23:1]).

Ports:
- clk  in  1  SDRAM clock.
- reset  in  1  synchronous active-high reset.
- cl_req  in  NUM_CLIENTS  level request; held high until the client's cl_ack pulse.
- cl_we  in  NUM_CLIENTS  1=write, 0=read.
- cl_a  in  NUM_CLIENTS*AW  word addresses; client i at [i*AW +: AW].
- cl_ds  in  NUM_CLIENTS*2  byte selects {upper,lower}; client i at [i*2 +: 2].
- cl_d  in  NUM_CLIENTS*16  write data.
- cl_ack  out  NUM_CLIENTS  one-cycle completion pulse.
- cl_q  out  16  read data of the last completed read; valid from the cl_ack cycle until the next read completes.
- mem_req  out  1  toggle request to the controller.
- mem_ack  in  1  controller ack; transaction done when mem_ack==mem_req (may be combinational).
- mem_we  out  1  latched write flag.
- mem_a  out  AW  latched address.
- mem_ds  out  2  latched byte selects.
- mem_d  out  16  latched write data.
- mem_q  in  16  controller read data; valid in the cycle mem_ack first equals mem_req.

Behaviour:
- Reset values:
  - State is SYNC.
  - mem_req=0, mem_we=0, mem_a=0, mem_ds=2'b11, mem_d=0.
  - cl_ack=0, cl_q=0, grant pointer=0.
- The clock and reset are single-domain. No CDC inside.
- SYNC:
  - Wait until mem_ack==mem_req, then go to IDLE.
  - This covers an unreset controller ack register and reset mid-transaction.
  - No issue is allowed from SYNC.
- IDLE:
  - If any cl_req is set, select winner w by the arbitration policy.
  - Latch cl_we[w], cl_a[w], cl_ds[w], cl_d[w] into mem_*.
  - Toggle mem_req, record w, go to WAIT.
  - Issue happens in the cycle after the first cl_req is seen high. The IDLE state itself is registered.
- WAIT:
  - mem_* are held stable and mem_req is not toggled.
  - On the first cycle mem_ack==mem_req:
    - if the access is a read, register cl_q<=mem_q;
    - go to DONE.
  - No timeout; the controller guarantees completion.
- DONE:
  - cl_ack[w]=1 for exactly this one cycle, with cl_q valid.
  - Go to IDLE.
- The client must drop cl_req in the cycle after cl_ack, or re-assert it for a new access. The arbiter ignores cl_req[w] during DONE to avoid a double issue.
- Minimum cycles per access: 3 + controller latency. Throughput is one outstanding access.
- Simultaneous requests are resolved only in IDLE. Requests arriving during WAIT/DONE are queued implicitly by the level cl_req.
- A client dropping cl_req during WAIT still gets its cl_ack; the access completes.
- Write: cl_q is unchanged and cl_ack is still pulsed.
- Reset asserted in WAIT: return to SYNC, keep mem_req at 0, drop the pending ack.
- Default policy is fixed priority: the lowest index wins.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. The search starts at index (last winner + 1) mod NUM_CLIENTS.
  - The pointer updates on issue only.
  - No client waits more than NUM_CLIENTS-1 other grants.
- Undefined:
  - Fixed priority; index 0 is highest.
  - The pointer logic is absent.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum {SYNC, IDLE, WAIT, DONE} (2 bits);
  - constant DS_NONE=2'b11;
  - function onehot_pick(req, start) returning the index.
- One sub-module: sdram_arb_pick.
  - Combinational priority/rotating picker.
  - Parameter NUM_CLIENTS.
  - Inputs: req, start. Outputs: valid, idx.

Test Plan:
- Reset with mem_ack=1 (mismatch) -> arbiter stays in SYNC with no mem_req toggle until mem_ack forced to 0; then cl_req[1]=1, cl_a[1]=23'h012345, read -> mem_req toggles 0->1, mem_a=23'h012345 stable until ack.
- Read with controller model returning mem_q=16'hBEEF, 8 cycles after toggle -> cl_ack[1] is a single pulse one cycle after the ack match, cl_q=16'hBEEF, and stays so through a following write.
- Write from client 2 (cl_d=16'h55AA, cl_ds=2'b01) -> mem_we=1, mem_ds=2'b01, mem_d=16'h55AA; cl_q unchanged; cl_ack[2] pulses once.
- All three clients request continuously, fixed priority -> client 0 granted every access and clients 1/2 starve. With SDRAM_ARB_RR_EN, the grant order is 0,1,2,0,1,2.
- Client 0 drops cl_req mid-WAIT -> access still completes, cl_ack[0] pulses, no second toggle.
- Reset asserted during WAIT -> mem_req=0, cl_ack all 0, state SYNC; the next issue occurs only after mem_ack==0.
